vga_clk_reconfig_ctrl: RTL and testbench



---
 rtl/vga_clk_reconfig_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_vga_clk_reconfig_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_clk_reconfig_ctrl.sv
// Pixel-clock reconfiguration controller: pushes a three-write AXI4-Lite sequence
// into the clocking wizard, then supervises MMCM lock with timeout and retry.
module vga_clk_reconfig_ctrl #(
  parameter int NUM_RES = 2,
  parameter int RES_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1,
  parameter logic [NUM_RES*64-1:0] CFG_TABLE = {32'h0001_0309, 32'h0000_0A01,
                                                32'h0000_0019, 32'h0000_0A01},
  parameter int LOCK_TIMEOUT = 2_000_000,
  parameter int UNLOCK_WAIT = 64,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk_100m_i,
  input  logic             arstn_i,
  input  logic             req_i,
  input  logic [RES_W-1:0] res_sel_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [RES_W-1:0] cur_res_o,
  output logic [10:0]      m_awaddr_o,
  output logic             m_awvalid_o,
  input  logic             m_awready_i,
  output logic [31:0]      m_wdata_o,
  output logic [3:0]       m_wstrb_o,
  output logic             m_wvalid_o,
  input  logic             m_wready_i,
  input  logic [1:0]       m_bresp_i,
  input  logic             m_bvalid_i,
  output logic             m_bready_o,
  input  logic             locked_i
);
  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high; valid is held with stable payload until then and drops the cycle after.
  localparam int CNT_MAX = (LOCK_TIMEOUT > UNLOCK_WAIT) ? LOCK_TIMEOUT : UNLOCK_WAIT;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_WAIT - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [RES_W:0]   NUM_RES_L   = (RES_W + 1)'(NUM_RES);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RESP, S_WAIT_UNLOCK, S_WAIT_LOCK, S_DONE, S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RES_W-1:0]   idx_q, idx_d;
  logic [RES_W-1:0]   cur_q, cur_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [10:0]        awaddr_q, awaddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               bready_q, bready_d;
  logic               aw_done, w_done;

  // Address/data for a given step of the sequence for one table entry.
  function automatic logic [42:0] wr_beat(input logic [RES_W-1:0] idx, input logic [1:0] step);
    logic [63:0] entry;
    entry = CFG_TABLE[64*int'(idx) +: 64];
    case (step)
      2'd0:    wr_beat = {11'h200, entry[31:0]};
      2'd1:    wr_beat = {11'h208, entry[63:32]};
      default: wr_beat = {11'h25C, 32'h0000_0003};
    endcase
  endfunction

  assign aw_done = !awvalid_q || m_awready_i;
  assign w_done  = !wvalid_q || m_wready_i;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    code_d    = code_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if ({1'b0, res_sel_i} < NUM_RES_L) begin
            idx_d     = res_sel_i;
            step_d    = 2'd0;
            retry_d   = '0;
            err_d     = 1'b0;
            code_d    = 2'b00;
            busy_d    = 1'b1;
            {awaddr_d, wdata_d} = wr_beat(res_sel_i, 2'd0);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WRITE;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = S_ERROR;
          end
        end
      end
      S_WRITE: begin
        if (awvalid_q && m_awready_i) awvalid_d = 1'b0;
        if (wvalid_q && m_wready_i) wvalid_d = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (m_bvalid_i) begin
          bready_d = 1'b0;
          if (m_bresp_i != 2'b00) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            busy_d  = 1'b0;
            state_d = S_ERROR;
          end else if (step_q == 2'd2) begin
            cnt_d   = '0;
            state_d = S_WAIT_UNLOCK;
          end else begin
            step_d    = step_q + 2'd1;
            {awaddr_d, wdata_d} = wr_beat(idx_q, step_q + 2'd1);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WRITE;
          end
        end
      end
      S_WAIT_UNLOCK: begin
        if (!locked_i || cnt_q == UNLOCK_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_i) begin
          valid_d = 1'b1;
          cur_d   = idx_q;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == LOCK_LAST) begin
          // A failed lock replays the whole write sequence from step 0.
          if (retry_q < RETRY_MAX) begin
            retry_d   = retry_q + 1'b1;
            step_d    = 2'd0;
            cnt_d     = '0;
            {awaddr_d, wdata_d} = wr_beat(idx_q, 2'd0);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WRITE;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            busy_d  = 1'b0;
            state_d = S_ERROR;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= S_IDLE;
      step_q    <= 2'd0;
      retry_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      cur_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      retry_q   <= retry_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      code_q    <= code_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;
  assign cur_res_o   = cur_q;
  assign m_awaddr_o  = awaddr_q;
  assign m_awvalid_o = awvalid_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = 4'hF;
  assign m_wvalid_o  = wvalid_q;
  assign m_bready_o  = bready_q;
endmodule

// File: tb/tb_vga_clk_reconfig_ctrl.sv
// Directed bench for vga_clk_reconfig_ctrl: vector table of requests against an
// AXI4-Lite slave model with programmable ready delays, error injection and lock.
module tb_vga_clk_reconfig_ctrl;
  localparam int NUM_RES = 3;
  localparam int RES_W = 2;
  localparam logic [NUM_RES*64-1:0] CFG = {32'h0000_0005, 32'h0000_0B02,
                                           32'h0001_0309, 32'h0000_0A01,
                                           32'h0000_0019, 32'h0000_0A01};
  localparam int DONE_LIMIT = 3000;

  logic             clk_100m_i = 1'b0;
  logic             arstn_i = 1'b0;
  logic             req_i = 1'b0;
  logic [RES_W-1:0] res_sel_i = '0;
  logic             busy_o, valid_o, err_o;
  logic [1:0]       err_code_o;
  logic [RES_W-1:0] cur_res_o;
  logic [10:0]      m_awaddr_o;
  logic             m_awvalid_o;
  logic             m_awready_i = 1'b0;
  logic [31:0]      m_wdata_o;
  logic [3:0]       m_wstrb_o;
  logic             m_wvalid_o;
  logic             m_wready_i = 1'b0;
  logic [1:0]       m_bresp_i = 2'b00;
  logic             m_bvalid_i = 1'b0;
  logic             m_bready_o;
  logic             locked_i = 1'b1;

  vga_clk_reconfig_ctrl #(
    .NUM_RES(NUM_RES), .CFG_TABLE(CFG), .LOCK_TIMEOUT(100), .UNLOCK_WAIT(8), .MAX_RETRY(2)
  ) dut (
    .clk_100m_i(clk_100m_i), .arstn_i(arstn_i), .req_i(req_i), .res_sel_i(res_sel_i),
    .busy_o(busy_o), .valid_o(valid_o), .err_o(err_o), .err_code_o(err_code_o),
    .cur_res_o(cur_res_o), .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o),
    .m_awready_i(m_awready_i), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_bresp_i(m_bresp_i),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .locked_i(locked_i)
  );

  // Clock / reset
  always #5 clk_100m_i = ~clk_100m_i;

  // Slave model knobs and bookkeeping
  int  aw_dly = 0, w_dly = 0, bad_b = -1;
  bit  lock_ok = 1'b1;
  int  aw_cnt = 0, w_cnt = 0, b_cnt = 0, unlock_cnt = 0, valid_cycles = 0;
  bit  aw_done = 0, w_done = 0, b_arm = 0, b_fire = 0;
  logic [10:0] aw_q[$];
  logic [31:0] w_q[$];
  logic [42:0] exp_q[$];
  logic [31:0] word_a [NUM_RES] = '{32'h0000_0A01, 32'h0000_0A01, 32'h0000_0B02};
  logic [31:0] word_b [NUM_RES] = '{32'h0000_0019, 32'h0001_0309, 32'h0000_0005};

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] sel;
    int         aw_dly;
    int         w_dly;
    int         bad_b;
    bit         lock_ok;
    int         n_wr;
    int         exp_valid;
    logic       exp_err;
    logic [1:0] exp_code;
    logic [1:0] exp_cur;
  } vec_t;
  vec_t vecs [8];

  // AXI slave + lock model: readies and bvalid change only on falling edges
  initial begin
    forever begin
      @(negedge clk_100m_i);
      if (!arstn_i) begin
        m_awready_i = 1'b0; m_wready_i = 1'b0; m_bvalid_i = 1'b0; m_bresp_i = 2'b00;
        aw_cnt = 0; w_cnt = 0; aw_done = 0; w_done = 0; b_arm = 0; b_fire = 0;
        unlock_cnt = 0;
      end else begin
        if (b_fire) begin m_bvalid_i = 1'b0; m_bresp_i = 2'b00; b_fire = 0; end
        if (b_arm) begin
          m_bvalid_i = 1'b1;
          m_bresp_i = (b_cnt == bad_b) ? 2'b10 : 2'b00;
          b_arm = 0;
        end
        if (m_awvalid_o) begin m_awready_i = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin m_awready_i = 1'b0; aw_cnt = 0; end
        if (m_wvalid_o) begin m_wready_i = (w_cnt >= w_dly); w_cnt++; end
        else begin m_wready_i = 1'b0; w_cnt = 0; end
        if (m_awvalid_o && m_awready_i) begin aw_q.push_back(m_awaddr_o); aw_done = 1; aw_cnt = 0; end
        if (m_wvalid_o && m_wready_i) begin w_q.push_back(m_wdata_o); w_done = 1; w_cnt = 0; end
        if (aw_done && w_done) begin b_arm = 1; aw_done = 0; w_done = 0; end
        if (m_bvalid_i && m_bready_o) begin
          b_cnt++;
          b_fire = 1;
          if (b_cnt % 3 == 0) unlock_cnt = 5;
        end
        if (unlock_cnt > 0) begin locked_i = 1'b0; unlock_cnt--; end
        else locked_i = lock_ok;
        if (valid_o) valid_cycles++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Driver: one request, wait for completion, then a quiet tail to catch extra traffic
  task automatic run_req(input logic [1:0] sel, input bit poke, output int cycles);
    aw_q.delete(); w_q.delete(); b_cnt = 0; valid_cycles = 0;
    @(negedge clk_100m_i);
    req_i = 1'b1; res_sel_i = sel;
    @(negedge clk_100m_i);
    req_i = 1'b0;
    cycles = 1;
    while (!(!busy_o && (valid_o || err_o)) && cycles < DONE_LIMIT) begin
      if (poke && cycles == 3) begin req_i = 1'b1; res_sel_i = 2'd2; end
      else req_i = 1'b0;
      @(negedge clk_100m_i);
      cycles++;
    end
    req_i = 1'b0;
    check("done_in_time", 64'(cycles < DONE_LIMIT), 64'd1);
    repeat (20) @(negedge clk_100m_i);
  endtask

  // Scoreboard: expected write stream is the 3-beat pattern repeated, truncated to n_wr
  task automatic check_writes(input string tag, input logic [1:0] sel, input int n_wr);
    logic [42:0] exp;
    exp_q.delete();
    for (int k = 0; k < n_wr; k++) begin
      case (k % 3)
        0:       exp_q.push_back({11'h200, word_a[sel]});
        1:       exp_q.push_back({11'h208, word_b[sel]});
        default: exp_q.push_back({11'h25C, 32'h0000_0003});
      endcase
    end
    check($sformatf("%s_aw_count", tag), 64'(aw_q.size()), 64'(n_wr));
    check($sformatf("%s_w_count", tag), 64'(w_q.size()), 64'(n_wr));
    check($sformatf("%s_b_count", tag), 64'(b_cnt), 64'(n_wr));
    for (int k = 0; k < aw_q.size() && k < w_q.size() && exp_q.size() > 0; k++) begin
      exp = exp_q.pop_front();
      check($sformatf("%s_wr%0d", tag, k), {21'd0, aw_q[k], w_q[k]}, {21'd0, exp});
    end
  endtask

  initial begin
    int cycles;
    int found;
    //            sel   awd wd bad lock n_wr val err code cur
    vecs[0] = '{2'd1, 0, 0, -1, 1'b1, 3, 1, 1'b0, 2'b00, 2'd1};
    vecs[1] = '{2'd0, 3, 0, -1, 1'b1, 3, 1, 1'b0, 2'b00, 2'd0};
    vecs[2] = '{2'd2, 0, 3, -1, 1'b1, 3, 1, 1'b0, 2'b00, 2'd2};
    vecs[3] = '{2'd1, 0, 0,  1, 1'b1, 2, 0, 1'b1, 2'b01, 2'd2};
    vecs[4] = '{2'd0, 0, 0, -1, 1'b0, 9, 0, 1'b1, 2'b10, 2'd2};
    vecs[5] = '{2'd0, 1, 1, -1, 1'b1, 3, 1, 1'b0, 2'b00, 2'd0};
    vecs[6] = '{2'd3, 0, 0, -1, 1'b1, 0, 0, 1'b1, 2'b11, 2'd0};
    vecs[7] = '{2'd1, 2, 2, -1, 1'b1, 3, 1, 1'b0, 2'b00, 2'd1};

    // Reset state
    arstn_i = 1'b0;
    repeat (3) @(negedge clk_100m_i);
    check("reset_outputs", {busy_o, valid_o, err_o, err_code_o, cur_res_o, m_awvalid_o,
                            m_wvalid_o, m_bready_o, m_awaddr_o, m_wdata_o}, 64'd0);
    check("reset_wstrb", 64'(m_wstrb_o), 64'hF);
    arstn_i = 1'b1;
    repeat (2) @(negedge clk_100m_i);

    for (int i = 0; i < 8; i++) begin
      aw_dly = vecs[i].aw_dly; w_dly = vecs[i].w_dly;
      bad_b = vecs[i].bad_b; lock_ok = vecs[i].lock_ok;
      run_req(vecs[i].sel, 1'b0, cycles);
      check_writes($sformatf("v%0d", i), vecs[i].sel, vecs[i].n_wr);
      check($sformatf("v%0d_valid_pulses", i), 64'(valid_cycles), 64'(vecs[i].exp_valid));
      check($sformatf("v%0d_err", i), 64'(err_o), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_code", i), 64'(err_code_o), 64'(vecs[i].exp_code));
      check($sformatf("v%0d_cur", i), 64'(cur_res_o), 64'(vecs[i].exp_cur));
      check($sformatf("v%0d_busy", i), 64'(busy_o), 64'd0);
      if (vecs[i].exp_code == 2'b11) check("bad_index_latency", 64'(cycles), 64'd1);
    end

    // Request and index change while busy are ignored
    aw_dly = 0; w_dly = 0; bad_b = -1; lock_ok = 1'b1;
    run_req(2'd0, 1'b1, cycles);
    check_writes("busy_req", 2'd0, 3);
    check("busy_req_valid", 64'(valid_cycles), 64'd1);
    check("busy_req_cur", 64'(cur_res_o), 64'd0);

    // Reset while step 1 address is pending
    aw_dly = 4;
    aw_q.delete(); w_q.delete(); b_cnt = 0;
    @(negedge clk_100m_i);
    req_i = 1'b1; res_sel_i = 2'd1;
    @(negedge clk_100m_i);
    req_i = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (m_awvalid_o && m_awaddr_o == 11'h208) found = 1;
      else @(negedge clk_100m_i);
    end
    check("midreset_reached_step1", 64'(found), 64'd1);
    #2 arstn_i = 1'b0;
    #1;
    check("midreset_outputs", {busy_o, valid_o, err_o, err_code_o, cur_res_o, m_awvalid_o,
                               m_wvalid_o, m_bready_o, m_awaddr_o, m_wdata_o}, 64'd0);
    @(negedge clk_100m_i);
    arstn_i = 1'b1;
    aw_dly = 0;
    run_req(2'd1, 1'b0, cycles);
    check_writes("post_reset", 2'd1, 3);
    check("post_reset_valid", 64'(valid_cycles), 64'd1);
    check("post_reset_cur", 64'(cur_res_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
